// File: rtl/pot_scan_seq.sv
// rtl/pot_scan_seq.sv - round-robin A2D pot scanner feeding six stable gain/volume registers
// Optional feature: define POT_SMOOTH_EN to low-pass each pot with a first-order IIR.
module pot_scan_seq #(
  parameter int GAP_CYC    = 64,
  parameter int RDY_SWEEPS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] VOL_pot,
  output logic        sweep_done,
  output logic        pots_rdy
);

  typedef enum logic [1:0] {S_GAP, S_START, S_WAIT, S_STORE} state_t;

  localparam logic [9:0] GAP_LAST  = 10'(GAP_CYC - 1);
  localparam logic [3:0] SWEEP_MAX = 4'(RDY_SWEEPS);

  state_t      state_q, state_d;
  logic [9:0]  gap_cnt_q, gap_cnt_d;
  logic [2:0]  slot_q, slot_d;
  logic [11:0] res_q, res_d;
  logic [11:0] pot_q [6];
  logic [11:0] pot_d [6];
  logic [3:0]  sweep_cnt_q, sweep_cnt_d;
  logic        sweep_done_q, sweep_done_d;
  logic        pots_rdy_q, pots_rdy_d;
  logic [11:0] cur_pot;
  logic [11:0] store_val;

`ifdef POT_SMOOTH_EN
  logic [5:0]         first_q, first_d;
  logic               cur_first;
  logic signed [13:0] diff, step, sum;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_GAP;
    else        state_q <= state_d;
  end

  // Next-state: idle gap, one-cycle start, wait for completion, one-cycle store
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GAP:   if (gap_cnt_q == GAP_LAST) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (cnv_cmplt) state_d = S_STORE;
      S_STORE: state_d = S_GAP;
      default: state_d = S_GAP;
    endcase
  end

  // FSM outputs: start pulse and fixed slot-to-channel map
  always_comb begin
    strt_cnv = (state_q == S_START);
    case (slot_q)
      3'd0:    chnnl = 3'd1;
      3'd1:    chnnl = 3'd0;
      3'd2:    chnnl = 3'd4;
      3'd3:    chnnl = 3'd2;
      3'd4:    chnnl = 3'd3;
      3'd5:    chnnl = 3'd7;
      default: chnnl = 3'd1;
    endcase
  end

  // Select the register addressed by the current slot
  always_comb begin
    cur_pot = '0;
    for (int i = 0; i < 6; i++)
      if (slot_q == 3'(i)) cur_pot = pot_q[i];
  end

`ifdef POT_SMOOTH_EN
  // IIR step new = old + (res - old)/4; first store after reset loads raw
  always_comb begin
    cur_first = 1'b0;
    for (int i = 0; i < 6; i++)
      if (slot_q == 3'(i)) cur_first = first_q[i];
    diff      = $signed({2'b00, res_q}) - $signed({2'b00, cur_pot});
    step      = diff >>> 2;
    sum       = $signed({2'b00, cur_pot}) + step;
    store_val = cur_first ? res_q : sum[11:0];
  end
`else
  // Raw result goes straight into the pot register
  always_comb begin
    store_val = res_q;
  end
`endif

  // Datapath next-state: gap counter, result capture, pot write, slot/sweep bookkeeping
  always_comb begin
    gap_cnt_d    = gap_cnt_q;
    slot_d       = slot_q;
    res_d        = res_q;
    pot_d        = pot_q;
    sweep_cnt_d  = sweep_cnt_q;
    sweep_done_d = 1'b0;
    pots_rdy_d   = pots_rdy_q | (sweep_cnt_q == SWEEP_MAX);
`ifdef POT_SMOOTH_EN
    first_d      = first_q;
`endif
    case (state_q)
      S_GAP:  gap_cnt_d = gap_cnt_q + 10'd1;
      S_WAIT: if (cnv_cmplt) res_d = res;
      S_STORE: begin
        for (int i = 0; i < 6; i++)
          if (slot_q == 3'(i)) begin
            pot_d[i] = store_val;
`ifdef POT_SMOOTH_EN
            first_d[i] = 1'b0;
`endif
          end
        gap_cnt_d = '0;
        if (slot_q == 3'd5) begin
          slot_d       = 3'd0;
          sweep_done_d = 1'b1;
          if (sweep_cnt_q != SWEEP_MAX) sweep_cnt_d = sweep_cnt_q + 4'd1;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt_q    <= '0;
      slot_q       <= '0;
      res_q        <= '0;
      for (int i = 0; i < 6; i++) pot_q[i] <= '0;
      sweep_cnt_q  <= '0;
      sweep_done_q <= 1'b0;
      pots_rdy_q   <= 1'b0;
`ifdef POT_SMOOTH_EN
      first_q      <= '1;
`endif
    end else begin
      gap_cnt_q    <= gap_cnt_d;
      slot_q       <= slot_d;
      res_q        <= res_d;
      pot_q        <= pot_d;
      sweep_cnt_q  <= sweep_cnt_d;
      sweep_done_q <= sweep_done_d;
      pots_rdy_q   <= pots_rdy_d;
`ifdef POT_SMOOTH_EN
      first_q      <= first_d;
`endif
    end
  end

  assign LP_pot     = pot_q[0];
  assign B1_pot     = pot_q[1];
  assign B2_pot     = pot_q[2];
  assign B3_pot     = pot_q[3];
  assign HP_pot     = pot_q[4];
  assign VOL_pot    = pot_q[5];
  assign sweep_done = sweep_done_q;
  assign pots_rdy   = pots_rdy_q;

endmodule

// File: tb/tb_pot_scan_seq.sv
// tb/tb_pot_scan_seq.sv - directed bench for pot_scan_seq
module tb_pot_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot;
  logic        sweep_done, pots_rdy;

  pot_scan_seq #(.GAP_CYC(64), .RDY_SWEEPS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cnv_cmplt(cnv_cmplt), .res(res),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .LP_pot(LP_pot), .B1_pot(B1_pot), .B2_pot(B2_pot), .B3_pot(B3_pot),
    .HP_pot(HP_pot), .VOL_pot(VOL_pot),
    .sweep_done(sweep_done), .pots_rdy(pots_rdy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor sampled just after each active edge
  int          cyc = 0;
  int          sd_cnt = 0;
  int          sd_cyc_q [$];
  logic [11:0] vol_at_sd = '0;
  int          b2_chg = 0;
  logic [11:0] b2_prev = '0;
  int          rdy_rise_cyc = -1;
  int          rdy_drop = 0;
  bit          rdy_arm = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sweep_done) begin
      sd_cnt++;
      sd_cyc_q.push_back(cyc);
      vol_at_sd = VOL_pot;
    end
    if (B2_pot != b2_prev) b2_chg++;
    b2_prev = B2_pot;
    if (pots_rdy && rdy_rise_cyc < 0) rdy_rise_cyc = cyc;
    if (rdy_arm && !pots_rdy) rdy_drop++;
  end

  task automatic wait_strt(output logic [2:0] ch, output int n);
    n  = 0;
    ch = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!strt_cnv && n < 3000);
    ch = chnnl;
    check("strt_seen", {31'b0, strt_cnv}, 32'd1);
  endtask

  // A2D model: 10-cycle conversion, result = base + channel
  task automatic conv(input int hold, input logic [11:0] base, output logic [2:0] ch, output int n);
    wait_strt(ch, n);
    repeat (10) @(negedge clk);
    check("chnnl_stable", {29'b0, chnnl}, {29'b0, ch});
    cnv_cmplt = 1'b1;
    res       = base + 12'(ch);
    repeat (hold) @(negedge clk);
    cnv_cmplt = 1'b0;
  endtask

  logic [2:0] ch_map [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
  logic [2:0] ch;
  int         n;

  initial begin
    rst_n = 1'b0; cnv_cmplt = 1'b0; res = '0;
    repeat (3) @(negedge clk);
    check("rst_strt", {31'b0, strt_cnv}, 32'd0);
    check("rst_chnnl", {29'b0, chnnl}, 32'd1);
    check("rst_lp", {20'b0, LP_pot}, 32'd0);
    check("rst_vol", {20'b0, VOL_pot}, 32'd0);
    check("rst_sd", {31'b0, sweep_done}, 32'd0);
    check("rst_rdy", {31'b0, pots_rdy}, 32'd0);
    rst_n = 1'b1;

    // Sweep 1: delays, channel order and captured values
    for (int s = 0; s < 6; s++) begin
      conv(1, 12'h100, ch, n);
      check("s1_ch", {29'b0, ch}, {29'b0, ch_map[s]});
      if (s == 0) begin
        check("first_strt_delay", n, 64);
        check("idle_lp", {20'b0, LP_pot}, 32'd0);
        check("idle_hp", {20'b0, HP_pot}, 32'd0);
      end else begin
        check("gap_delay", n, 65);
      end
    end
    repeat (3) @(negedge clk);
    check("s1_lp", {20'b0, LP_pot}, 32'h101);
    check("s1_b1", {20'b0, B1_pot}, 32'h100);
    check("s1_b2", {20'b0, B2_pot}, 32'h104);
    check("s1_b3", {20'b0, B3_pot}, 32'h102);
    check("s1_hp", {20'b0, HP_pot}, 32'h103);
    check("s1_vol", {20'b0, VOL_pot}, 32'h107);
    check("s1_sd_cnt", sd_cnt, 1);
    check("s1_vol_at_sd", {20'b0, vol_at_sd}, 32'h107);
    check("s1_rdy", {31'b0, pots_rdy}, 32'd0);

    // Sweep 2: pots_rdy one cycle after the second sweep_done
    for (int s = 0; s < 6; s++) begin
      conv(1, 12'h100, ch, n);
      check("s2_ch", {29'b0, ch}, {29'b0, ch_map[s]});
    end
    repeat (3) @(negedge clk);
    check("s2_sd_cnt", sd_cnt, 2);
    check("s2_rdy", {31'b0, pots_rdy}, 32'd1);
    check("rdy_timing", rdy_rise_cyc, sd_cyc_q[1] + 1);
    rdy_arm = 1'b1;

    // Sweep 3: cnv_cmplt held 8 cycles on slot2
    conv(1, 12'h100, ch, n);
    conv(1, 12'h100, ch, n);
    b2_chg = 0;
    conv(8, 12'h200, ch, n);
    check("hold_ch", {29'b0, ch}, 32'd4);
    conv(1, 12'h100, ch, n);
    check("hold_next_ch", {29'b0, ch}, 32'd2);
    check("hold_gap", n, 58);
    check("hold_b2_writes", b2_chg, 1);
`ifdef POT_SMOOTH_EN
    check("hold_b2", {20'b0, B2_pot}, 32'h144);
`else
    check("hold_b2", {20'b0, B2_pot}, 32'h204);
`endif
    conv(1, 12'h100, ch, n);
    conv(1, 12'h100, ch, n);

    // Sweeps 4..7: pots_rdy must stay high
    for (int k = 0; k < 24; k++) begin
      conv(1, 12'h100, ch, n);
      check("s47_ch", {29'b0, ch}, {29'b0, ch_map[k % 6]});
    end
    repeat (3) @(negedge clk);
    check("s7_sd_cnt", sd_cnt, 7);
    check("rdy_sticky", rdy_drop, 0);
    check("s7_rdy", {31'b0, pots_rdy}, 32'd1);
    check("s7_lp", {20'b0, LP_pot}, 32'h101);
    check("s7_vol", {20'b0, VOL_pot}, 32'h107);

    // Reset while waiting on slot3, then a stray completion
    conv(1, 12'h100, ch, n);
    conv(1, 12'h100, ch, n);
    conv(1, 12'h100, ch, n);
    wait_strt(ch, n);
    check("rst_wait_ch", {29'b0, ch}, 32'd2);
    repeat (3) @(negedge clk);
    rdy_arm = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cnv_cmplt = 1'b1; res = 12'hABC;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_lp", {20'b0, LP_pot}, 32'd0);
    check("mid_rst_b1", {20'b0, B1_pot}, 32'd0);
    check("mid_rst_b2", {20'b0, B2_pot}, 32'd0);
    check("mid_rst_b3", {20'b0, B3_pot}, 32'd0);
    check("mid_rst_hp", {20'b0, HP_pot}, 32'd0);
    check("mid_rst_vol", {20'b0, VOL_pot}, 32'd0);
    check("mid_rst_rdy", {31'b0, pots_rdy}, 32'd0);
    sd_cnt = 0;
    conv(1, 12'h7FF, ch, n);
    check("post_rst_ch", {29'b0, ch}, 32'd1);
    check("post_rst_delay", n, 58);
    repeat (3) @(negedge clk);
    check("post_rst_lp", {20'b0, LP_pot}, 32'h800);
    check("post_rst_b1", {20'b0, B1_pot}, 32'd0);

`ifdef POT_SMOOTH_EN
    // IIR on LP: 0x800 then 0x000, 0x000
    for (int k = 0; k < 5; k++) conv(1, 12'h100, ch, n);
    conv(1, 12'hFFF, ch, n);
    repeat (3) @(negedge clk);
    check("iir_lp_1", {20'b0, LP_pot}, 32'h600);
    for (int k = 0; k < 5; k++) conv(1, 12'h100, ch, n);
    conv(1, 12'hFFF, ch, n);
    repeat (3) @(negedge clk);
    check("iir_lp_2", {20'b0, LP_pot}, 32'h480);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
